dec_cmp_arbiter: RTL
====================

# dec_cmp_arbiter

Shares one `dec_comparator` instance between `NUM_REQ` requesters in the decoder datapath. Each requester submits an operand pair (A, B) with a valid/ready handshake. The block grants requesters round-robin and drives registered operands into the comparator. It then samples the comparator's `isEqual` and returns the result to the granted requester with a response handshake. Saturating statistics counters track total comparisons and matches for debug readout.

## Interface
Parameters:
- `DATA_DEPTH`, default 8: operand width; must match the attached comparator.
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `CNT_WIDTH`, default 16: statistics counter width.

Ports:
- `clk`  in  1  — single clock; all state updates on its rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  — per-requester request valid.
- `req_a`  in  NUM_REQ*DATA_DEPTH  — flattened A operands; requester i at bits [i*DATA_DEPTH +: DATA_DEPTH].
- `req_b`  in  NUM_REQ*DATA_DEPTH  — flattened B operands, same packing as `req_a`.
- `req_ready`  out  NUM_REQ  — one-hot grant; request accepted on a cycle where valid and ready are both 1.
- `rsp_valid`  out  NUM_REQ  — one-hot response valid to the granted requester.
- `rsp_ready`  in  NUM_REQ  — per-requester response accept.
- `rsp_isEqual`  out  1  — comparison result, qualified by `rsp_valid`.
- `cmp_A`, `cmp_B`  out  DATA_DEPTH  — registered operands to the comparator's A and B inputs.
- `cmp_isEqual`  in  1  — comparator output.
- `busy`  out  1  — high in any state other than IDLE.
- `stat_clr`  in  1  — synchronous clear of both statistics counters.
- `cmp_count`, `match_count`  out  CNT_WIDTH  — completed comparisons, and completed comparisons with `isEqual`=1.

## Operation
- FSM states are IDLE, COMPARE and RESPOND.
- **IDLE:**
  - If any `req_valid` is set, assert `req_ready` for the grant index g.
  - g is the first index with `req_valid`=1, searching upward from `rr_ptr` with wrap at NUM_REQ.
  - `req_ready` is combinational from `req_valid` and `rr_ptr`. It is zero outside IDLE.
  - On acceptance: latch req_a[g] into `cmp_A` and req_b[g] into `cmp_B`, store g, set `rr_ptr` = (g+1) mod NUM_REQ, then go to COMPARE.
- **COMPARE:** lasts exactly one cycle with `cmp_A`/`cmp_B` stable. At the end of the cycle:
  - register `cmp_isEqual` into `rsp_isEqual`;
  - set `rsp_valid[g]` = 1;
  - increment `cmp_count`, and increment `match_count` if `cmp_isEqual`=1;
  - go to RESPOND.
- **RESPOND:**
  - Hold `rsp_valid[g]` and `rsp_isEqual` until `rsp_ready[g]`=1.
  - On that edge, clear `rsp_valid` and return to IDLE.
  - `rsp_ready` bits of other requesters are ignored.
- `cmp_A`/`cmp_B` keep their last value after completion and change only on acceptance.
- Requesters must hold `req_valid` and operands stable until accepted. A requester dropping `req_valid` before grant simply loses its turn; this is not an error.
- Counters saturate at 2^CNT_WIDTH−1 and never wrap. `match_count` ≤ `cmp_count` always.
- Reset:
  - state goes to IDLE, `rr_ptr`=0, and all outputs and counters are 0 (`cmp_A`, `cmp_B` = 0);
  - reset mid-operation discards the in-flight comparison with no response and no counter update;
  - reset overrides `stat_clr`.
- `stat_clr` asserted on the same edge as a counter increment: the clear wins and the counter reads 0.

## Timing
- Acceptance edge E0 → COMPARE during cycle E0..E1 → `rsp_valid` high after E1. Response latency is 1 cycle after the accept edge.
- Minimum transaction is 3 cycles (IDLE, COMPARE, RESPOND with `rsp_ready` already high). Peak throughput is 1 comparison per 3 cycles.
- The comparator path from `cmp_A`/`cmp_B` through `dec_comparator` to the `rsp_isEqual` register is one full cycle.
- `req_ready` and `busy` are never high in the same cycle. `rsp_valid` is at most one-hot.

## Test plan
- Single request, equal operands: requester 0 with A=0x5A, B=0x5A.
  - Required: `req_ready`=0001 in the request cycle; `rsp_valid`=0001 and `rsp_isEqual`=1 one cycle after acceptance; `cmp_count`=1, `match_count`=1.
- Round-robin fairness: all 4 requesters hold valid continuously, each with rsp_ready=1.
  - Required: grants go 0,1,2,3,0,1…, one grant every 3 cycles; requester 2 has A=0x10, B=0x11 and sees `rsp_isEqual`=0.
- Response backpressure: requester 1 holds rsp_ready=0 for 5 cycles.
  - Required: `rsp_valid`=0010 and `rsp_isEqual` stay stable, `busy`=1, no new grant to requester 3 despite its valid; grant to requester 3 occurs 1 cycle after rsp_ready rises.
- Reset mid-COMPARE:
  - Required: all outputs 0 next cycle, no response, counters unchanged at 0; the next request after reset is granted from index 0.
- Counter saturation and clear: CNT_WIDTH=4, run 17 equal compares.
  - Required: both counters stop at 15. `stat_clr` pulsed on an increment edge leaves both counters at 0.
- Pointer wrap: requesters 3 and 0 both valid with `rr_ptr`=3.
  - Required: 3 is granted, then 0; after 0 the pointer is 1, so a simultaneous request from 1 and 3 grants 1.

Source files
------------

// File: rtl/dec_cmp_arbiter.sv
// dec_cmp_arbiter
// Shares one external dec_comparator between NUM_REQ requesters. Requests are
// granted round-robin and the chosen operand pair is registered onto cmp_A/cmp_B.
// After one compare cycle the comparator's isEqual is registered and returned to
// the granted requester through a valid/ready response handshake. Saturating
// counters track completed comparisons and matches.
//
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   req_valid/req_ready   - per-requester request handshake (ready is one-hot grant)
//   req_a, req_b          - flattened operands, requester i at [i*DATA_DEPTH +: DATA_DEPTH]
//   rsp_valid/rsp_ready   - per-requester response handshake (valid is one-hot)
//   rsp_isEqual           - comparison result, qualified by rsp_valid
//   cmp_A, cmp_B          - registered operands driven to the comparator
//   cmp_isEqual           - comparator result
//   busy                  - FSM outside IDLE
//   stat_clr              - synchronous clear of both statistics counters
//   cmp_count/match_count - saturating comparison / match counters
module dec_cmp_arbiter #(
    parameter int DATA_DEPTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*DATA_DEPTH-1:0]   req_a,
    input  logic [NUM_REQ*DATA_DEPTH-1:0]   req_b,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic [NUM_REQ-1:0]              rsp_valid,
    input  logic [NUM_REQ-1:0]              rsp_ready,
    output logic                            rsp_isEqual,
    output logic [DATA_DEPTH-1:0]           cmp_A,
    output logic [DATA_DEPTH-1:0]           cmp_B,
    input  logic                            cmp_isEqual,
    output logic                            busy,
    input  logic                            stat_clr,
    output logic [CNT_WIDTH-1:0]            cmp_count,
    output logic [CNT_WIDTH-1:0]            match_count
);

    localparam int PW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
    localparam logic [PW:0] NUM_REQ_W = (PW+1)'(NUM_REQ);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPARE = 2'd1,
        S_RESPOND = 2'd2
    } state_t;

    state_t                  state_q;
    logic [PW-1:0]           rr_ptr_q;
    logic [PW-1:0]           gidx_q;
    logic [DATA_DEPTH-1:0]   cmp_a_q;
    logic [DATA_DEPTH-1:0]   cmp_b_q;
    logic [NUM_REQ-1:0]      rsp_valid_q;
    logic                    rsp_is_equal_q;
    logic [CNT_WIDTH-1:0]    cmp_count_q;
    logic [CNT_WIDTH-1:0]    match_count_q;

    logic [2*NUM_REQ-1:0]    vdbl_s;
    logic                    grant_found_s;
    logic [PW-1:0]           grant_idx_s;
    logic [PW:0]             sum_s;
    logic [PW:0]             next_s;
    logic [PW-1:0]           rr_ptr_d;
    logic [DATA_DEPTH-1:0]   sel_a_s;
    logic [DATA_DEPTH-1:0]   sel_b_s;
    logic [NUM_REQ-1:0]      gidx_onehot_s;
    logic [CNT_WIDTH-1:0]    cmp_count_d;
    logic [CNT_WIDTH-1:0]    match_count_d;

    // Round-robin search: rotate the valid vector so rr_ptr sits at bit 0, take
    // the first set bit, then map the offset back to an absolute index.
    always_comb begin
        vdbl_s        = {req_valid, req_valid} >> rr_ptr_q;
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        sum_s         = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_found_s && vdbl_s[k]) begin
                grant_found_s = 1'b1;
                sum_s = {1'b0, rr_ptr_q} + (PW+1)'(k);
                if (sum_s >= NUM_REQ_W) begin
                    sum_s = sum_s - NUM_REQ_W;
                end else begin
                    sum_s = sum_s;
                end
                grant_idx_s = sum_s[PW-1:0];
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Pointer advance past the grant, operand mux and grant/response one-hots.
    always_comb begin
        next_s = {1'b0, grant_idx_s} + {{PW{1'b0}}, 1'b1};
        if (next_s >= NUM_REQ_W) begin
            rr_ptr_d = '0;
        end else begin
            rr_ptr_d = next_s[PW-1:0];
        end
        sel_a_s       = '0;
        sel_b_s       = '0;
        req_ready     = '0;
        gidx_onehot_s = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_idx_s == PW'(k)) begin
                sel_a_s = req_a[k*DATA_DEPTH +: DATA_DEPTH];
                sel_b_s = req_b[k*DATA_DEPTH +: DATA_DEPTH];
                req_ready[k] = (state_q == S_IDLE) && grant_found_s;
            end else begin
                req_ready[k] = 1'b0;
            end
            if (gidx_q == PW'(k)) begin
                gidx_onehot_s[k] = 1'b1;
            end else begin
                gidx_onehot_s[k] = 1'b0;
            end
        end
    end

    // Saturating next values for the statistics counters.
    always_comb begin
        if (cmp_count_q == {CNT_WIDTH{1'b1}}) begin
            cmp_count_d = cmp_count_q;
        end else begin
            cmp_count_d = cmp_count_q + CNT_WIDTH'(1);
        end
        if (match_count_q == {CNT_WIDTH{1'b1}}) begin
            match_count_d = match_count_q;
        end else begin
            match_count_d = match_count_q + CNT_WIDTH'(1);
        end
    end

    // Arbitration FSM with registered operands, response and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            rr_ptr_q       <= '0;
            gidx_q         <= '0;
            cmp_a_q        <= '0;
            cmp_b_q        <= '0;
            rsp_valid_q    <= '0;
            rsp_is_equal_q <= 1'b0;
            cmp_count_q    <= '0;
            match_count_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (grant_found_s) begin
                        cmp_a_q  <= sel_a_s;
                        cmp_b_q  <= sel_b_s;
                        gidx_q   <= grant_idx_s;
                        rr_ptr_q <= rr_ptr_d;
                        state_q  <= S_COMPARE;
                    end
                end
                S_COMPARE: begin
                    rsp_is_equal_q <= cmp_isEqual;
                    rsp_valid_q    <= gidx_onehot_s;
                    cmp_count_q    <= cmp_count_d;
                    if (cmp_isEqual) begin
                        match_count_q <= match_count_d;
                    end
                    state_q <= S_RESPOND;
                end
                S_RESPOND: begin
                    // Only the granted requester's rsp_ready completes the response.
                    if (rsp_ready[gidx_q]) begin
                        rsp_valid_q <= '0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= '0;
                    state_q     <= S_IDLE;
                end
            endcase
            // Clear takes priority over any increment on the same edge.
            if (stat_clr) begin
                cmp_count_q   <= '0;
                match_count_q <= '0;
            end
        end
    end

    assign cmp_A       = cmp_a_q;
    assign cmp_B       = cmp_b_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_isEqual = rsp_is_equal_q;
    assign busy        = (state_q != S_IDLE);
    assign cmp_count   = cmp_count_q;
    assign match_count = match_count_q;

endmodule
